// File: rtl/controle_seq_if.sv
// Instruction handshake and control-code bundle between the sequencer and its user.
// The master side issues instructions; the slave side (the sequencer) drives the codes and status.
interface controle_seq_if #(
    parameter int CODE_W = 4,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_opc;
    logic [CNT_W-1:0]  in_cnt;
    logic              auto_repeat;
    logic [CODE_W-1:0] tx;
    logic [CODE_W-1:0] ty;
    logic [CODE_W-1:0] tz;
    logic [CODE_W-1:0] tula;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output in_valid, in_opc, in_cnt, auto_repeat,
        input  in_ready, tx, ty, tz, tula, busy, done, err
    );

    modport slave (
        input  in_valid, in_opc, in_cnt, auto_repeat,
        output in_ready, tx, ty, tz, tula, busy, done, err
    );
endinterface

// File: rtl/controle_seq.sv
// Register/ULA control sequencer for the X/Y/Z datapath: runs one per-opcode micro-sequence
// per accepted instruction and drives registered (Moore) control codes and status.
module controle_seq #(
    parameter int CODE_W = 4,
    parameter int CNT_W  = 4
) (
    input logic           clock,
    input logic           reset,
    controle_seq_if.slave bus
);
    localparam logic [CODE_W-1:0] CLEAR  = CODE_W'(0);
    localparam logic [CODE_W-1:0] LOAD   = CODE_W'(1);
    localparam logic [CODE_W-1:0] HOLD   = CODE_W'(2);
    localparam logic [CODE_W-1:0] SHIFTR = CODE_W'(3);
    localparam logic [CODE_W-1:0] SHIFTL = CODE_W'(4);
    localparam logic [CODE_W-1:0] PASS   = CODE_W'(0);

    localparam logic [2:0] OPC_SHR = 3'd4;
    localparam logic [2:0] OPC_SHL = 3'd5;
    localparam logic [2:0] OPC_CLR = 3'd6;

    typedef enum logic [2:0] {IDLE, LOADX, LOADY, SHIFT, WRITEZ, CLRALL, ERR} state_t;

    state_t            state, state_n;
    logic [2:0]        opc, opc_n;
    logic [CNT_W-1:0]  cnt_lat, cnt_lat_n;
    logic [CNT_W-1:0]  count, count_n;
    logic [CODE_W-1:0] tx_q, ty_q, tz_q, tula_q;
    logic [CODE_W-1:0] tx_n, ty_n, tz_n, tula_n;
    logic              busy_q, done_q, err_q, ready_q;
    logic              busy_n, done_n, err_n, ready_n;
    logic              is_shift_n;

    // Next state plus the outputs that belong to it, so every output comes straight from a flop.
    always_comb begin
        state_n   = state;
        opc_n     = opc;
        cnt_lat_n = cnt_lat;
        count_n   = count;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    opc_n     = bus.in_opc;
                    cnt_lat_n = bus.in_cnt;
                    if (bus.in_opc < OPC_CLR)       state_n = LOADX;
                    else if (bus.in_opc == OPC_CLR) state_n = CLRALL;
                    else                            state_n = ERR;
                end
            end
            LOADX: state_n = LOADY;
            LOADY: begin
                if ((opc == OPC_SHR || opc == OPC_SHL) && cnt_lat != '0) begin
                    state_n = SHIFT;
                    count_n = cnt_lat;
                end else begin
                    state_n = WRITEZ;
                end
            end
            SHIFT: begin
                count_n = count - CNT_W'(1);
                if (count == CNT_W'(1)) state_n = WRITEZ;
            end
            WRITEZ:  state_n = bus.auto_repeat ? LOADX : IDLE;
            CLRALL:  state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        is_shift_n = (opc_n == OPC_SHR) || (opc_n == OPC_SHL);
        tx_n    = HOLD;
        ty_n    = HOLD;
        tz_n    = HOLD;
        tula_n  = PASS;
        busy_n  = (state_n != IDLE);
        ready_n = (state_n == IDLE);
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state_n)
            LOADX: tx_n = LOAD;
            LOADY: ty_n = LOAD;
            SHIFT: ty_n = (opc_n == OPC_SHR) ? SHIFTR : SHIFTL;
            WRITEZ: begin
                tz_n   = LOAD;
                done_n = 1'b1;
                // ALU opcodes 0..3 map onto ULA codes ADD..OR, one above the opcode.
                tula_n = is_shift_n ? PASS : CODE_W'(opc_n) + CODE_W'(1);
            end
            CLRALL: begin
                tx_n   = CLEAR;
                ty_n   = CLEAR;
                tz_n   = CLEAR;
                done_n = 1'b1;
            end
            ERR: begin
                done_n = 1'b1;
                err_n  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            opc     <= '0;
            cnt_lat <= '0;
            count   <= '0;
            tx_q    <= HOLD;
            ty_q    <= HOLD;
            tz_q    <= HOLD;
            tula_q  <= PASS;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_n;
            opc     <= opc_n;
            cnt_lat <= cnt_lat_n;
            count   <= count_n;
            tx_q    <= tx_n;
            ty_q    <= ty_n;
            tz_q    <= tz_n;
            tula_q  <= tula_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
            ready_q <= ready_n;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.ty       = ty_q;
    assign bus.tz       = tz_q;
    assign bus.tula     = tula_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.in_ready = ready_q;
endmodule
